data_path_p: RTL
================

DATA_PATH_P -- requirements
Module: data_path_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bus, IR and AC width, minimum 4.
REQ-002 SHALL have parameter OP_W, default 2: opcode field width; ADR_W = DATA_W-OP_W is a derived localparam.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all registers rising-edge.
- rst  in  1  synchronous, active-high reset.
- data_bus_in  in  DATA_W  memory read data.
- ld_ir, ld_ac, ld_pc, inc_pc, clr_pc  in  1 each  register controls.
- ac_src  in  1  0 = AC loads data_bus_in; 1 = AC loads ALU result.
- alu_op  in  2  00 pass A, 01 add, 10 sub, 11 and.
- ir_on_adr, pc_on_adr  in  1 each  address source selects.
- adr_bus  out  ADR_W  memory address.
- op_code  out  OP_W  IR[DATA_W-1 -: OP_W].
- data_bus_out  out  DATA_W  ALU result, for memory write.
- zero_flag, carry_flag  out  1 each  registered ALU flags.

Function
REQ-004 SHALL define ALU operand A = AC and operand B = IR[ADR_W-1:0] zero-extended to DATA_W.
REQ-005 SHALL compute the ALU result combinationally, truncated to DATA_W:
- pass: A.
- add: A+B, carry = bit DATA_W of the sum.
- sub: A-B, carry = 1 when A<B (borrow).
- and: A&B, carry = 0.
REQ-006 SHALL drive data_bus_out with the ALU result in the same cycle, with no register stage.
REQ-007 SHALL load IR from data_bus_in on the edge where ld_ir=1, and hold it otherwise.
REQ-008 SHALL update AC on the edge where ld_ac=1, from data_bus_in or the ALU result as selected by ac_src.
REQ-009 SHALL update flags only on ld_ac=1 edges:
- zero_flag = (new AC == 0).
- carry_flag = ALU carry when ac_src=1; carry_flag = 0 when ac_src=0.
REQ-010 SHALL give PC the priority clr_pc > ld_pc > inc_pc > hold:
- ld_pc loads IR[ADR_W-1:0].
- inc_pc increments modulo 2^ADR_W; all-ones wraps to 0 with no flag.
REQ-011 SHALL drive adr_bus as IR[ADR_W-1:0] if ir_on_adr=1, else PC if pc_on_adr=1, else 0; ir_on_adr wins when both are 1.
REQ-012 SHALL, when ld_ir and ld_pc are both 1, load PC from the pre-edge IR value.
REQ-013 SHALL, when ld_ir and ld_ac(ac_src=1) are both 1, compute AC from the pre-edge IR value.
REQ-014 SHALL make op_code and adr_bus combinational decodes of registered state and controls only.

Reset
REQ-015 SHALL clear IR, AC, PC, zero_flag and carry_flag to 0 on any rising edge with rst=1.
REQ-016 SHALL give rst priority over every load, increment and scan control, including a reset that lands mid-sequence.
REQ-017 SHALL, immediately after reset, output adr_bus=0, op_code=0 and data_bus_out=0 for all alu_op values except 11, which also gives 0.

Configuration
REQ-018 SHALL, when macro DATA_PATH_SCAN_CHAIN_EN is defined, add ports scan_en (in, 1), scan_in (in, 1) and scan_out (out, 1).
REQ-019 SHALL, with scan_en=1 and rst=0, shift one bit per edge through a single chain and ignore all functional load controls:
- chain order: scan_in -> AC[0..DATA_W-1] -> IR[0..DATA_W-1] -> PC[0..ADR_W-1] -> carry_flag -> zero_flag.
- scan_out = zero_flag.
- chain length = 2*DATA_W+ADR_W+2.
REQ-020 SHALL, without DATA_PATH_SCAN_CHAIN_EN, omit the three scan ports and contain no scan logic.

Verification
REQ-021 SHALL cover reset: set all registers nonzero, pulse rst for 1 cycle -> all outputs 0 on the next cycle.
REQ-022 SHALL cover accumulate (DATA_W=8):
- ld_ir with 0x05.
- ld_ac with 0xFE, ac_src=0.
- ld_ac, ac_src=1, alu_op=01 -> AC=0x03, carry=1, zero=0.
REQ-023 SHALL cover subtract to zero: AC=0x05, IR=0x05, alu_op=10, ac_src=1, ld_ac -> AC=0x00, zero=1, carry=0.
REQ-024 SHALL cover PC wrap and priority:
- PC=0x3F, inc_pc -> 0x00.
- clr_pc, ld_pc and inc_pc together -> 0x00.
- ld_pc with inc_pc, IR=0x2A -> 0x2A.
REQ-025 SHALL cover the address mux: IR=0x15, PC=0x07; ir_on_adr=1, pc_on_adr=1 -> adr_bus=0x15; pc_on_adr only -> 0x07; neither -> 0x00.
REQ-026 SHALL cover scan (macro defined, DATA_W=8):
- shift a 24-bit pattern with scan_en=1 -> scan_out replays it after 24 cycles.
- rst asserted mid-shift -> chain cleared.

Source files
------------

// File: rtl/data_path_p.sv
// Accumulator datapath: IR/AC/PC registers, a 4-op ALU, flags and an address mux.
// Latency: ALU result and address are combinational; registers update on the next rising edge.
// Backpressure: none; the controller drives the load strobes directly every cycle.
// Optional scan chain through all state, enabled by macro DATA_PATH_SCAN_CHAIN_EN.
module data_path_p #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_bus_in,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              clr_pc,
  input  logic              ac_src,
  input  logic [1:0]        alu_op,
  input  logic              ir_on_adr,
  input  logic              pc_on_adr,
`ifdef DATA_PATH_SCAN_CHAIN_EN
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
`endif
  output logic [DATA_W-OP_W-1:0] adr_bus,
  output logic [OP_W-1:0]   op_code,
  output logic [DATA_W-1:0] data_bus_out,
  output logic              zero_flag,
  output logic              carry_flag
);

  localparam int ADR_W = DATA_W - OP_W;

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [ADR_W-1:0]  pc;
  logic              zf;
  logic              cf;

  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cy;
  logic [DATA_W-1:0] ac_next;
  logic              cy_next;

  // Operand B is the IR address field, zero-extended to the data width.
  assign opb = {{OP_W{1'b0}}, ir[ADR_W-1:0]};

  // ALU: one extra bit on sum/difference gives carry-out and borrow directly.
  always_comb begin
    sum     = {1'b0, ac} + {1'b0, opb};
    diff    = {1'b0, ac} - {1'b0, opb};
    alu_res = ac;
    alu_cy  = 1'b0;
    case (alu_op)
      2'b01: begin
        alu_res = sum[DATA_W-1:0];
        alu_cy  = sum[DATA_W];
      end
      2'b10: begin
        alu_res = diff[DATA_W-1:0];
        alu_cy  = diff[DATA_W];
      end
      2'b11: begin
        alu_res = ac & opb;
        alu_cy  = 1'b0;
      end
      default: begin
        alu_res = ac;
        alu_cy  = 1'b0;
      end
    endcase
  end

  // AC source select; a memory load always clears carry.
  always_comb begin
    ac_next = ac_src ? alu_res : data_bus_in;
    cy_next = ac_src ? alu_cy  : 1'b0;
  end

  // State registers: reset wins, then scan shift (if built in), then functional loads.
  // All right-hand sides use pre-edge IR, so simultaneous ld_ir with ld_pc/ld_ac sees the old IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
      ac <= '0;
      pc <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
    end
`ifdef DATA_PATH_SCAN_CHAIN_EN
    else if (scan_en) begin
      ac <= {ac[DATA_W-2:0], scan_in};
      ir <= {ir[DATA_W-2:0], ac[DATA_W-1]};
      pc <= {pc[ADR_W-2:0], ir[DATA_W-1]};
      cf <= pc[ADR_W-1];
      zf <= cf;
    end
`endif
    else begin
      if (ld_ir) begin
        ir <= data_bus_in;
      end
      if (ld_ac) begin
        ac <= ac_next;
        zf <= (ac_next == '0);
        cf <= cy_next;
      end
      if (clr_pc) begin
        pc <= '0;
      end else if (ld_pc) begin
        pc <= ir[ADR_W-1:0];
      end else if (inc_pc) begin
        pc <= pc + ADR_W'(1);
      end
    end
  end

  // Address mux: IR field has priority over PC; idle bus reads as zero.
  always_comb begin
    if (ir_on_adr) begin
      adr_bus = ir[ADR_W-1:0];
    end else if (pc_on_adr) begin
      adr_bus = pc;
    end else begin
      adr_bus = '0;
    end
  end

  assign op_code      = ir[DATA_W-1 -: OP_W];
  assign data_bus_out = alu_res;
  assign zero_flag    = zf;
  assign carry_flag   = cf;

`ifdef DATA_PATH_SCAN_CHAIN_EN
  assign scan_out = zf;
`endif

endmodule
